proj3_axil_arbiter: RTL and testbench
=====================================

PROJ3_AXIL_ARBITER -- requirements
Module: proj3_axil_arbiter
Interface
REQ-001 SHALL have parameter ADDR_W, default 4, AXI4-Lite byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port ACLK  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port ARESET  in  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  in  2  per-requester request, held until its rsp_valid.
REQ-006 SHALL have port req_we  in  2  per-requester 1=write, 0=read.
REQ-007 SHALL have port req_addr  in  2*ADDR_W  per-requester address, [ADDR_W-1:0]=requester 0.
REQ-008 SHALL have port req_wdata  in  2*DATA_W  per-requester write data.
REQ-009 SHALL have port rsp_valid  out  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_resp  out  2  AXI response code, valid with rsp_valid.
REQ-012 SHALL have ports M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1 (write address channel).
REQ-013 SHALL have ports M_AXI_WDATA out DATA_W, M_AXI_WSTRB out DATA_W/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1 (write data channel).
REQ-014 SHALL have ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1 (write response channel).
REQ-015 SHALL have ports M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1 (read address channel).
REQ-016 SHALL have ports M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1 (read data channel).
Function
REQ-017 SHALL implement FSM states IDLE, WADDR, WRESP, RADDR, RDATA, RSP; exactly one AXI transaction outstanding.
REQ-018 In IDLE with any req_valid high, SHALL grant one requester, register its we/addr/wdata, and go to WADDR (we=1) or RADDR (we=0).
REQ-019 WADDR SHALL assert AWVALID and WVALID together; each SHALL drop independently on its own handshake; go to WRESP when both are done, including same-cycle completion.
REQ-020 WSTRB SHALL be all ones; AWADDR/ARADDR/WDATA SHALL be the registered values, stable while VALID is high.
REQ-021 WRESP SHALL hold BREADY=1; on BVALID SHALL capture BRESP, set rsp_rdata=0, go to RSP.
REQ-022 RADDR SHALL hold ARVALID until ARREADY, then go to RDATA; RDATA SHALL hold RREADY=1 and on RVALID capture RDATA/RRESP, then go to RSP.
REQ-023 RSP SHALL pulse rsp_valid[grant] for exactly one cycle, ignore all requests, and return to IDLE.
REQ-024 Zero-wait-slave latency SHALL be: grant edge T, AW/W or AR handshake T+1, B or R handshake T+2, rsp_valid high in cycle T+3.
REQ-025 Tie-break SHALL be round-robin: priority pointer moves to the non-granted requester after every grant; a lone requester is always granted.
REQ-026 req_valid dropped mid-transaction SHALL NOT abort it; transaction completes and rsp_valid still pulses.
Reset
REQ-027 ARESET SHALL immediately force all VALID/READY outputs, rsp_valid, rsp_rdata and rsp_resp to 0, FSM to IDLE and the priority pointer to requester 0, including mid-transaction.
Configuration
REQ-028 With PROJ3_ARB_FIXED_PRIO_EN defined, requester 0 SHALL win every tie; without it, REQ-025 round-robin SHALL apply.
Structure
REQ-029 Package proj3_arb_pkg SHALL hold the FSM state enum, NUM_REQ=2, and the response constants OKAY=2'b00 and SLVERR=2'b10.
REQ-030 Grant/pointer logic SHALL be the sub-module proj3_rr_arbiter.
Verification
REQ-031 req0 write addr 0x4 data 0xDEADBEEF, zero-wait slave -> AW/W handshake at T+1, rsp_valid[0] at T+3, rsp_resp=00.
REQ-032 Slave register 0x8 holds 0x00000003; req1 reads 0x8 -> rsp_valid[1] with rsp_rdata=0x00000003, rsp_resp=00.
REQ-033 Both req_valid held high from reset for 4 transactions -> grant order 0,1,0,1; with PROJ3_ARB_FIXED_PRIO_EN, req0 wins each tie.
REQ-034 AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID high 3 cycles, BREADY asserted only after both handshakes.
REQ-035 Slave returns BRESP=2'b10 -> rsp_resp=2'b10 with rsp_valid.
REQ-036 ARESET pulsed in RDATA -> all outputs 0 in the same cycle; first request after release is granted with pointer at requester 0.

Source files
------------

// File: rtl/proj3_arb_pkg.sv
// ---------------------------------------------------------------------------
// proj3_arb_pkg
// Purpose : shared definitions for the two-requester AXI4-Lite arbiter.
// Contents: NUM_REQ (number of requesters), AXI response codes OKAY/SLVERR,
//           and the bus-master FSM state enum used by proj3_axil_arbiter.
// ---------------------------------------------------------------------------
package proj3_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

endpackage

// File: rtl/proj3_rr_arbiter.sv
// ---------------------------------------------------------------------------
// proj3_rr_arbiter
// Purpose : picks one of two requesters and keeps the priority pointer.
//           A lone requester always wins; on a tie the pointer decides.
//           After every accepted grant the pointer moves to the requester
//           that was not granted.
// Config  : define PROJ3_ARB_FIXED_PRIO_EN to make requester 0 win every tie
//           (the pointer is then parked on requester 0).
// Ports   : clk_i          rising-edge clock
//           rst_i          asynchronous active-high reset (pointer -> 0)
//           req_i          per-requester request
//           advance_i      the grant presented this cycle is being taken
//           grant_valid_o  at least one requester is asking
//           grant_idx_o    index of the chosen requester
// ---------------------------------------------------------------------------
module proj3_rr_arbiter
  import proj3_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic               grant_valid_o,
  output logic               grant_idx_o
);

  logic ptr_q, ptr_d;

  // If the requester under the pointer is asking it wins; otherwise the
  // other one must be the only requester (when grant_valid_o is high).
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef PROJ3_ARB_FIXED_PRIO_EN
    // Pointer stays home so requester 0 always takes the tie.
    if (advance_i) begin
      ptr_d = 1'b0;
    end
`else
    if (advance_i) begin
      ptr_d = ~grant_idx_o;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/proj3_axil_arbiter.sv
// ---------------------------------------------------------------------------
// proj3_axil_arbiter
// Purpose : shares one AXI4-Lite master port between two simple requesters.
//           Exactly one AXI transaction is outstanding at any time. A granted
//           request is latched, so dropping req_valid mid-transaction does
//           not abort it; completion is a one-cycle rsp_valid pulse on the
//           granted requester's bit.
// Config  : PROJ3_ARB_FIXED_PRIO_EN (in proj3_rr_arbiter) selects fixed
//           priority for requester 0 instead of round-robin on ties.
// Ports   : ACLK, ARESET          clock / asynchronous active-high reset
//           req_valid/we/addr/wdata  per-requester request (packed, req 0 low)
//           rsp_valid/rdata/resp     completion pulse, read data, AXI resp
//           M_AXI_AW*/W*/B*/AR*/R*   AXI4-Lite master channels
// ---------------------------------------------------------------------------
module proj3_axil_arbiter
  import proj3_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  // requester side
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                  rsp_resp,
  // write address channel
  output logic [ADDR_W-1:0]           M_AXI_AWADDR,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  // write data channel
  output logic [DATA_W-1:0]           M_AXI_WDATA,
  output logic [DATA_W/8-1:0]         M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  // read address channel
  output logic [ADDR_W-1:0]           M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  // read data channel
  input  logic [DATA_W-1:0]           M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  state_t              state_q,   state_d;
  logic                grant_q,   grant_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q,  wvalid_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic [1:0]          resp_q,    resp_d;

  logic                arb_valid;
  logic                arb_idx;
  logic                arb_advance;

  // Unpacked views of the packed per-requester buses.
  logic [ADDR_W-1:0]   req_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   req_wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      // Derived from the state register so the pulse is exactly one cycle
      // and drops immediately on reset.
      assign rsp_valid[gi]     = (state_q == RSP) && (grant_q == 1'(gi));
    end
  endgenerate

  // Requests are only considered in IDLE; RSP ignores them.
  assign arb_advance = (state_q == IDLE) && arb_valid;

  proj3_rr_arbiter u_arb (
    .clk_i         (ACLK),
    .rst_i         (ARESET),
    .req_i         (req_valid),
    .advance_i     (arb_advance),
    .grant_valid_o (arb_valid),
    .grant_idx_o   (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          addr_d  = req_addr_arr[arb_idx];
          wdata_d = req_wdata_arr[arb_idx];
          if (req_we[arb_idx]) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
          end
        end
      end

      WADDR: begin
        // AW and W retire independently; leave once both are gone,
        // which covers both finishing in the same cycle.
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q  && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = RSP;
        end
      end

      RADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = RDATA;
        end
      end

      RDATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = RSP;
        end
      end

      RSP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Address/data come straight from the registered request, so they are
  // stable for as long as the matching VALID is high.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = (state_q == RADDR);
  assign M_AXI_RREADY  = (state_q == RDATA);

  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_proj3_axil_arbiter.sv
// ---------------------------------------------------------------------------
// tb_proj3_axil_arbiter
// Directed and randomized checks of proj3_axil_arbiter against a small
// AXI4-Lite slave (four 32-bit registers, programmable wait states and
// response codes) and a transaction-level reference model.
// Honours PROJ3_ARB_FIXED_PRIO_EN for tie-break expectations.
// ---------------------------------------------------------------------------
module tb_proj3_axil_arbiter;
  import proj3_arb_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  M_AXI_AWADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [3:0]  M_AXI_ARADDR;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  logic        t_we    [2];
  logic [3:0]  t_addr  [2];
  logic [31:0] t_wdata [2];
  assign req_we    = {t_we[1], t_we[0]};
  assign req_addr  = {t_addr[1], t_addr[0]};
  assign req_wdata = {t_wdata[1], t_wdata[0]};

  proj3_axil_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0] bresp_cfg, rresp_cfg;

  logic [31:0] smem [4];
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic [3:0]  aw_a, r_a;
  logic [31:0] w_d;
  logic [1:0]  b_r, r_r;

  logic aw_hs, w_hs, b_hs, ar_hs;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_wait) && !aw_got;
  assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_wait)  && !w_got;
  assign M_AXI_BVALID  = b_pend && (b_cnt >= b_wait);
  assign M_AXI_BRESP   = b_r;
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_wait);
  assign M_AXI_RVALID  = r_pend && (r_cnt >= r_wait);
  assign M_AXI_RDATA   = M_AXI_RVALID ? smem[r_a[3:2]] : 32'h0;
  assign M_AXI_RRESP   = r_r;

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs    = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wr_addr = aw_hs ? M_AXI_AWADDR : aw_a;
  assign wr_data = w_hs  ? M_AXI_WDATA  : w_d;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      smem[0] <= 32'h0; smem[1] <= 32'h0; smem[2] <= 32'h3; smem[3] <= 32'h0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= 4'h0; r_a <= 4'h0; w_d <= 32'h0; b_r <= OKAY; r_r <= OKAY;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (b_pend) begin
        if (b_hs) b_pend <= 1'b0;
        else      b_cnt  <= b_cnt + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        if (bresp_cfg == OKAY) smem[wr_addr[3:2]] <= wr_data;
        aw_got <= 1'b0; w_got <= 1'b0;
        b_pend <= 1'b1; b_cnt <= 0; b_r <= bresp_cfg;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
        if (w_hs)  begin w_got  <= 1'b1; w_d  <= M_AXI_WDATA;  end
      end
      if (ar_hs) begin
        r_pend <= 1'b1; r_cnt <= 0; r_a <= M_AXI_ARADDR; r_r <= rresp_cfg;
      end else if (r_pend) begin
        if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 1'b0;
        else                              r_cnt  <= r_cnt + 1;
      end
    end
  end

  // ---------------- cycle monitor ----------------
  int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, rsp_cyc = 0;
  int awv_cnt = 0, wv_cnt = 0, bready_bad = 0;
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (aw_hs) aw_hs_cyc <= cyc;
    if (w_hs)  w_hs_cyc  <= cyc;
    if (b_hs)  b_hs_cyc  <= cyc;
    if (rsp_valid != 2'b00) rsp_cyc <= cyc;
    if (M_AXI_AWVALID) awv_cnt <= awv_cnt + 1;
    if (M_AXI_WVALID)  wv_cnt  <= wv_cnt + 1;
    if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) bready_bad <= bready_bad + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] mem_ref [4];
  logic        ptr_m;
  int checks = 0;
  int failures = 0;

  task automatic model_reset();
    mem_ref[0] = 32'h0; mem_ref[1] = 32'h0; mem_ref[2] = 32'h3; mem_ref[3] = 32'h0;
    ptr_m = 1'b0;
  endtask

  // Who should win, given which requesters are pending.
  function automatic int pick(input logic [1:0] pend);
    if (pend == 2'b11) begin
`ifdef PROJ3_ARB_FIXED_PRIO_EN
      return 0;
`else
      return int'(ptr_m);
`endif
    end
    return pend[1] ? 1 : 0;
  endfunction

  // Apply requester w's transaction to the model; return expected response.
  task automatic predict(input int w, output logic [31:0] exp_data, output logic [1:0] exp_resp);
    if (t_we[w]) begin
      exp_data = 32'h0;
      exp_resp = bresp_cfg;
      if (bresp_cfg == OKAY) mem_ref[t_addr[w][3:2]] = t_wdata[w];
    end else begin
      exp_data = mem_ref[t_addr[w][3:2]];
      exp_resp = rresp_cfg;
    end
    ptr_m = (w == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input int aw, input int wd, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr);
    aw_wait = aw; w_wait = wd; b_wait = b; ar_wait = ar; r_wait = r;
    bresp_cfg = br; rresp_cfg = rr;
  endtask

  task automatic wait_rsp();
    int budget;
    budget = 0;
    @(posedge ACLK); #1;
    while (rsp_valid == 2'b00 && budget < 200) begin
      @(posedge ACLK); #1;
      budget++;
    end
    chk("rsp_wait_bound", 32'(budget < 200), 32'd1);
  endtask

  // Serve every requester in mask; checks order, data, resp and pulse width.
  task automatic serve(input logic [1:0] mask, input bit drop_early);
    logic [1:0]  pend;
    logic [31:0] ed;
    logic [1:0]  er;
    int w;
    pend = mask;
    req_valid = mask;
    while (pend != 2'b00) begin
      w = pick(pend);
      predict(w, ed, er);
      if (drop_early) begin
        @(posedge ACLK); #1;
        req_valid = 2'b00;
      end
      wait_rsp();
      chk("rsp_valid_onehot", {30'b0, rsp_valid}, {30'b0, 2'(1 << w)});
      chk("rsp_rdata", rsp_rdata, ed);
      chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, er});
      $display("txn req%0d we=%0d addr=0x%0h wdata=0x%08h rdata=0x%08h resp=%0d",
               w, t_we[w], t_addr[w], t_wdata[w], rsp_rdata, rsp_resp);
      req_valid[w] = 1'b0;
      pend[w] = 1'b0;
      @(posedge ACLK); #1;
      chk("rsp_pulse_width", {30'b0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed;
    logic [1:0]  er;
    int w, t0, a0, w0, bb0, budget;

    ARESET = 1'b1;
    req_valid = 2'b00;
    for (int r = 0; r < 2; r++) begin t_we[r] = 1'b0; t_addr[r] = 4'h0; t_wdata[r] = 32'h0; end
    set_slave(0, 0, 0, 0, 0, OKAY, OKAY);
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_valid_ready", {27'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                              M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("reset_rsp", {28'b0, rsp_valid, rsp_resp}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);

    // Both requesters held high from reset release: four reads in a row.
    t_addr[0] = 4'h0; t_addr[1] = 4'h8;
    req_valid = 2'b11;
    @(negedge ACLK); ARESET = 1'b0;
    chk("wstrb", {28'b0, M_AXI_WSTRB}, 32'h0000000F);
    for (int k = 0; k < 4; k++) begin
      w = pick(2'b11);
      predict(w, ed, er);
      wait_rsp();
      chk("tie_order", {30'b0, rsp_valid}, {30'b0, 2'(1 << w)});
      chk("tie_rdata", rsp_rdata, ed);
      $display("txn tie%0d req%0d rdata=0x%08h", k, w, rsp_rdata);
    end
    req_valid = 2'b00;
    @(posedge ACLK); #1;

    // Lone requester 1 reads register 0x8 (preset to 3).
    t_we[1] = 1'b0; t_addr[1] = 4'h8;
    serve(2'b10, 1'b0);

    // Zero-wait write latency from requester 0.
    t_we[0] = 1'b1; t_addr[0] = 4'h4; t_wdata[0] = 32'hDEADBEEF;
    t0 = cyc;
    serve(2'b01, 1'b0);
    chk("lat_aw", 32'(aw_hs_cyc - t0), 32'd1);
    chk("lat_w",  32'(w_hs_cyc - t0),  32'd1);
    chk("lat_b",  32'(b_hs_cyc - t0),  32'd2);
    chk("lat_rsp", 32'(rsp_cyc - t0),  32'd3);

    // AWREADY late, WREADY immediate.
    set_slave(2, 0, 0, 0, 0, OKAY, OKAY);
    a0 = awv_cnt; w0 = wv_cnt; bb0 = bready_bad;
    t_we[0] = 1'b1; t_addr[0] = 4'h0; t_wdata[0] = 32'h12345678;
    serve(2'b01, 1'b0);
    chk("awvalid_cycles", 32'(awv_cnt - a0), 32'd3);
    chk("wvalid_cycles",  32'(wv_cnt - w0),  32'd1);
    chk("bready_early",   32'(bready_bad - bb0), 32'd0);
    chk("b_after_aw",     32'(b_hs_cyc - aw_hs_cyc), 32'd1);

    // Slave error on a write.
    set_slave(0, 0, 0, 0, 0, SLVERR, OKAY);
    t_we[1] = 1'b1; t_addr[1] = 4'hC; t_wdata[1] = 32'hCAFEF00D;
    serve(2'b10, 1'b0);

    // Request withdrawn right after the grant must still complete.
    set_slave(0, 1, 1, 0, 0, OKAY, OKAY);
    t_we[0] = 1'b1; t_addr[0] = 4'hC; t_wdata[0] = 32'h00000055;
    serve(2'b01, 1'b1);
    t_we[1] = 1'b0; t_addr[1] = 4'hC;
    serve(2'b10, 1'b1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? SLVERR : OKAY,
                ($urandom_range(0, 3) == 0) ? SLVERR : OKAY);
      for (int r = 0; r < 2; r++) begin
        t_we[r]    = 1'($urandom_range(0, 1));
        t_addr[r]  = 4'($urandom_range(0, 3) << 2);
        t_wdata[r] = $urandom;
      end
      serve(2'($urandom_range(1, 3)), 1'b0);
    end

    // Reset in the middle of a read data phase.
    set_slave(0, 0, 0, 0, 20, OKAY, OKAY);
    t_we[0] = 1'b0; t_addr[0] = 4'h8;
    req_valid = 2'b01;
    ptr_m = 1'b1;
    budget = 0;
    @(posedge ACLK); #1;
    while (!M_AXI_RREADY && budget < 50) begin @(posedge ACLK); #1; budget++; end
    chk("reached_rdata", {31'b0, M_AXI_RREADY}, 32'd1);
    @(negedge ACLK); #2;
    ARESET = 1'b1;
    #1;
    chk("mid_reset_valid_ready", {27'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                  M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("mid_reset_rsp", {28'b0, rsp_valid, rsp_resp}, 32'd0);
    chk("mid_reset_rdata", rsp_rdata, 32'd0);
    req_valid = 2'b00;
    model_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    set_slave(0, 0, 0, 0, 0, OKAY, OKAY);
    t_we[0] = 1'b0; t_addr[0] = 4'h8;
    t_we[1] = 1'b0; t_addr[1] = 4'h0;
    serve(2'b11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
